// File: rtl/bus_timer_pkg.sv
// Shared definitions for the memory-mapped periodic bus timer: register map,
// CTRL bit positions, interrupt FSM states and a read-back helper.
package bus_timer_pkg;

  localparam int unsigned DATA_W     = 8;
  localparam int unsigned ADDR_W     = 8;
  localparam int unsigned OFFSET_W   = 2;
  localparam int unsigned PRESCALE_W = 16;
  localparam int unsigned COMPARE_W  = DATA_W + 1;

  localparam logic [OFFSET_W-1:0] OFF_COUNT  = 2'd0;
  localparam logic [OFFSET_W-1:0] OFF_PERIOD = 2'd1;
  localparam logic [OFFSET_W-1:0] OFF_CTRL   = 2'd2;
  localparam logic [OFFSET_W-1:0] OFF_STATUS = 2'd3;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  typedef enum logic {
    IRQ_IDLE   = 1'b0,
    IRQ_RAISED = 1'b1
  } irqState_t;

  // Read-back image of CTRL: only the two defined bits are ever non-zero.
  function automatic logic [DATA_W-1:0] ctrlByte(input logic en, input logic irqEn);
    logic [DATA_W-1:0] value;
    value              = '0;
    value[CTRL_EN]     = en;
    value[CTRL_IRQ_EN] = irqEn;
    return value;
  endfunction

endpackage

// File: rtl/bus_timer_responder_prescaler.sv
// Divides CLK down to a one-cycle TICK every CLKS_PER_TICK enabled cycles.
module timer_prescaler #(
  parameter int unsigned CLKS_PER_TICK = 50000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);
  import bus_timer_pkg::*;

  localparam logic [PRESCALE_W-1:0] LAST_COUNT = PRESCALE_W'(CLKS_PER_TICK - 1);

  logic [PRESCALE_W-1:0] preCount;

  // Clear beats enable so a COUNT write restarts the tick period from zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      preCount <= '0;
    end else if (CLR) begin
      preCount <= '0;
    end else if (EN) begin
      if (preCount == LAST_COUNT) begin
        preCount <= '0;
      end else begin
        preCount <= preCount + PRESCALE_W'(1);
      end
    end
  end

  // Decoded from registered state; frozen low while the timer is disabled.
  assign TICK = EN && (preCount == LAST_COUNT);

endmodule

// File: rtl/bus_timer_responder.sv
// Periodic millisecond timer on the shared tristate bus: 4-byte register
// window, one-cycle read latency, level interrupt held until ack or clear.
module bus_timer_responder #(
  parameter logic [7:0]  BASE_ADDR      = 8'hF0,
  parameter int unsigned CLKS_PER_TICK  = 50000,
  parameter logic [7:0]  DEFAULT_PERIOD = 8'd100
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);
  import bus_timer_pkg::*;

  logic                  inWindow;
  logic [OFFSET_W-1:0]   regOffset;
  logic                  regWrite;
  logic                  regRead;
  logic                  countWrite;
  logic                  ctrlWrite;
  logic                  statusClear;

  logic [DATA_W-1:0]     count;
  logic [DATA_W-1:0]     period;
  logic                  ctrlEn;
  logic                  ctrlIrqEn;
  logic                  pending;

  logic [DATA_W-1:0]     regReadValue;
  logic [DATA_W-1:0]     readData;
  logic                  driveEn;

  logic                  tick;
  logic [COMPARE_W-1:0]  countPlusOne;
  logic                  timerEvent;

  irqState_t             state;
  irqState_t             stateNext;
  logic                  pendingNext;
  logic                  irqEnNext;

  // Address decode: the window is the 4-aligned block starting at BASE_ADDR.
  assign inWindow    = (BUS_ADDR[ADDR_W-1:OFFSET_W] == BASE_ADDR[ADDR_W-1:OFFSET_W]);
  assign regOffset   = BUS_ADDR[OFFSET_W-1:0];
  assign regWrite    = BUS_WE && inWindow;
  assign regRead     = !BUS_WE && inWindow;
  assign countWrite  = regWrite && (regOffset == OFF_COUNT);
  assign ctrlWrite   = regWrite && (regOffset == OFF_CTRL);
  assign statusClear = regWrite && (regOffset == OFF_STATUS) && BUS_DATA[0];

  timer_prescaler #(
    .CLKS_PER_TICK(CLKS_PER_TICK)
  ) u_prescaler (
    .CLK  (CLK),
    .RESET(RESET),
    .EN   (ctrlEn),
    .CLR  (countWrite),
    .TICK (tick)
  );

  // 9-bit compare so a PERIOD below COUNT fires on the next tick, never wraps.
  assign countPlusOne = COMPARE_W'(count) + COMPARE_W'(1);
  assign timerEvent   = tick && !countWrite && (period != '0) &&
                        (countPlusOne >= COMPARE_W'(period));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count <= '0;
    end else if (countWrite) begin
      count <= '0;
    end else if (tick) begin
      if (period == '0) begin
        count <= count + DATA_W'(1);
      end else if (timerEvent) begin
        count <= '0;
      end else begin
        count <= count + DATA_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      period    <= DEFAULT_PERIOD;
      ctrlEn    <= 1'b0;
      ctrlIrqEn <= 1'b0;
    end else if (regWrite) begin
      case (regOffset)
        OFF_PERIOD: period <= BUS_DATA;
        OFF_CTRL: begin
          ctrlEn    <= BUS_DATA[CTRL_EN];
          ctrlIrqEn <= BUS_DATA[CTRL_IRQ_EN];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    regReadValue = '0;
    case (regOffset)
      OFF_COUNT:  regReadValue = count;
      OFF_PERIOD: regReadValue = period;
      OFF_CTRL:   regReadValue = ctrlByte(ctrlEn, ctrlIrqEn);
      OFF_STATUS: regReadValue = {{(DATA_W-1){1'b0}}, pending};
      default:    regReadValue = '0;
    endcase
  end

  // Read data is captured in the address cycle and presented one cycle later.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      driveEn  <= 1'b0;
      readData <= '0;
    end else begin
      driveEn <= regRead;
      if (regRead) begin
        readData <= regReadValue;
      end
    end
  end

  // The initiator owns the bus whenever it strobes a write.
  assign BUS_DATA = (driveEn && !BUS_WE) ? readData : {DATA_W{1'bz}};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state               <= IRQ_IDLE;
      pending             <= 1'b0;
      BUS_INTERRUPT_RAISE <= 1'b0;
    end else begin
      state               <= stateNext;
      pending             <= pendingNext;
      BUS_INTERRUPT_RAISE <= (stateNext == IRQ_RAISED);
    end
  end

  // A new event always beats an ack or clear arriving in the same cycle.
  always_comb begin
    stateNext   = state;
    pendingNext = pending;
    irqEnNext   = ctrlWrite ? BUS_DATA[CTRL_IRQ_EN] : ctrlIrqEn;
    case (state)
      IRQ_IDLE: begin
        if (timerEvent) begin
          pendingNext = 1'b1;
        end else if (statusClear) begin
          pendingNext = 1'b0;
        end
        if (irqEnNext && pendingNext) begin
          stateNext = IRQ_RAISED;
        end
      end
      IRQ_RAISED: begin
        if (timerEvent) begin
          pendingNext = 1'b1;
        end else if (statusClear || BUS_INTERRUPT_ACK) begin
          pendingNext = 1'b0;
        end
        if (!irqEnNext || !pendingNext) begin
          stateNext = IRQ_IDLE;
        end
      end
      default: begin
        stateNext = IRQ_IDLE;
      end
    endcase
  end

endmodule
